// File: rtl/clock_domain_pkg.sv
// ============================================================================
// Module   : clock_domain_pkg
// Brief    : Shared state encoding for the valid/ack clock-domain handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_domain_pkg;

    localparam int c_STATE_W = 2;

    typedef logic [c_STATE_W-1:0] state_t;

    // Common to the import and export sides of the handshake.
    localparam state_t IDLE           = 2'd0;
    localparam state_t WAIT_VALID_LOW = 2'd1;
    localparam state_t WAIT_RELEASE   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/clock_domain_import_if.sv
// ============================================================================
// Module   : clock_domain_import_if
// Brief    : Handshake side and local valid/ready side of the importer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_domain_import_if #(
    parameter int SIZE = 7
) ();

    logic [SIZE-1:0] handshake_data;
    logic            handshake_valid;
    logic            handshake_ack;
    logic [SIZE-1:0] data;
    logic            valid;
    logic            ready;

    // master: the importer itself; slave: the source and the local consumer.
    modport master (
        input  handshake_data,
        input  handshake_valid,
        output handshake_ack,
        output data,
        output valid,
        input  ready
    );

    modport slave (
        output handshake_data,
        output handshake_valid,
        input  handshake_ack,
        input  data,
        input  valid,
        output ready
    );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Parameterised-width two-flop synchronizer, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/clock_domain_import.sv
// ============================================================================
// Module   : clock_domain_import
// Brief    : Destination side of the valid/ack CDC handshake with a one-deep
//            output buffer presented on a local valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_domain_import
    import clock_domain_pkg::*;
#(
    parameter int SIZE = 7
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    clock_domain_import_if.master bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ack;
    logic            w_ack_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic [SIZE-1:0] r_data;
    logic [SIZE-1:0] w_data_nxt;
    logic            w_valid_sync;
    logic            w_buf_free;
    logic            w_capture;

    sync_2ff #(
        .WIDTH (1)
    ) u_valid_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.handshake_valid),
        .o_q   (w_valid_sync)
    );

    // A consume in the same cycle frees the slot for a new capture.
    assign w_buf_free = !r_valid || bus.ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ack_nxt = 1'b0;
                if (w_valid_sync && w_buf_free) begin
                    w_capture   = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = WAIT_VALID_LOW;
                end
            end
            WAIT_VALID_LOW: begin
                w_ack_nxt = 1'b1;
                if (!w_valid_sync) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // Ack low is registered before another capture can start.
                w_ack_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase

        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        if (w_capture) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = bus.handshake_data;
        end else if (r_valid && bus.ready) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.handshake_ack = r_ack;
    assign bus.valid         = r_valid;
    assign bus.data          = r_data;

endmodule

`default_nettype wire

// File: tb/tb_clock_domain_import.sv
// ============================================================================
// Module   : tb_clock_domain_import
// Brief    : Directed self-checking bench for clock_domain_import.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_domain_import;

    localparam int c_SIZE     = 7;
    localparam int c_N_STREAM = 32;

    logic clk     = 1'b0;
    logic src_clk = 1'b0;
    logic rst_n   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    int exp_next = 0;
    bit src_done = 1'b0;

    clock_domain_import_if #(.SIZE(c_SIZE)) bus ();

    clock_domain_import #(
        .SIZE (c_SIZE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5  clk     = ~clk;
    always #11 src_clk = ~src_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream monitor: ready is stable from #1 after posedge, so a transfer
    // seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (mon_en && bus.valid && bus.ready) begin
            check("stream_word", 32'(bus.data), 32'(exp_next));
            exp_next++;
        end
    end

    task automatic src_send(input logic [c_SIZE-1:0] w);
        int cnt;
        @(posedge src_clk);
        bus.handshake_data = w;
        @(posedge src_clk);
        bus.handshake_valid = 1'b1;
        cnt = 0;
        while (!bus.handshake_ack && cnt < 200) begin
            @(posedge src_clk);
            cnt++;
        end
        if (cnt >= 200) check("ack_rise_timeout", 32'd0, 32'd1);
        bus.handshake_valid = 1'b0;
        cnt = 0;
        while (bus.handshake_ack && cnt < 200) begin
            @(posedge src_clk);
            cnt++;
        end
        if (cnt >= 200) check("ack_fall_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.handshake_data  = '0;
        bus.handshake_valid = 1'b0;
        bus.ready           = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ack",   32'(bus.handshake_ack), 32'd0);
        check("rst_valid", 32'(bus.valid),         32'd0);
        check("rst_data",  32'(bus.data),          32'd0);
        rst_n = 1'b1;
        tick();

        // Single transfer: capture two edges after valid is first sampled
        bus.ready = 1'b1;
        bus.handshake_data  = 7'h55;
        bus.handshake_valid = 1'b1;
        tick();
        check("t1_ack_n",   32'(bus.handshake_ack), 32'd0);
        tick();
        check("t1_ack_n1",  32'(bus.handshake_ack), 32'd0);
        check("t1_vld_n1",  32'(bus.valid),         32'd0);
        tick();
        check("t1_ack_n2",  32'(bus.handshake_ack), 32'd1);
        check("t1_vld_n2",  32'(bus.valid),         32'd1);
        check("t1_data",    32'(bus.data),          32'h55);
        tick();
        check("t1_vld_one", 32'(bus.valid),         32'd0);
        bus.handshake_valid = 1'b0;
        tick();
        check("t1_ack_hold1", 32'(bus.handshake_ack), 32'd1);
        tick();
        check("t1_ack_hold2", 32'(bus.handshake_ack), 32'd1);
        tick();
        check("t1_ack_low",   32'(bus.handshake_ack), 32'd0);
        check("t1_data_hold", 32'(bus.data),          32'h55);
        tick();

        // Backpressure, then simultaneous consume and capture
        bus.ready = 1'b0;
        bus.handshake_data  = 7'h12;
        bus.handshake_valid = 1'b1;
        tick(); tick(); tick();
        check("bp_first_data", 32'(bus.data), 32'h12);
        bus.handshake_valid = 1'b0;
        tick(); tick(); tick(); tick();
        bus.handshake_data  = 7'h34;
        bus.handshake_valid = 1'b1;
        tick(); tick(); tick(); tick();
        check("bp_ack_low",  32'(bus.handshake_ack), 32'd0);
        check("bp_data_12",  32'(bus.data),          32'h12);
        check("bp_valid",    32'(bus.valid),         32'd1);
        bus.ready = 1'b1;
        #1;
        check("bp_xfer_12",  32'(bus.data),          32'h12);
        tick();
        check("swap_data",   32'(bus.data),          32'h34);
        check("swap_valid",  32'(bus.valid),         32'd1);
        check("swap_ack",    32'(bus.handshake_ack), 32'd1);
        tick();
        check("bp_drained",  32'(bus.valid),         32'd0);
        bus.handshake_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("bp_idle_ack", 32'(bus.handshake_ack), 32'd0);

        // Reset mid-operation in WAIT_VALID_LOW
        bus.ready = 1'b0;
        bus.handshake_data  = 7'h2A;
        bus.handshake_valid = 1'b1;
        tick(); tick(); tick();
        check("mr_pre_ack", 32'(bus.handshake_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_ack",   32'(bus.handshake_ack), 32'd0);
        check("mr_valid", 32'(bus.valid),         32'd0);
        check("mr_data",  32'(bus.data),          32'd0);
        bus.handshake_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("mr_post_ack",   32'(bus.handshake_ack), 32'd0);
        check("mr_post_valid", 32'(bus.valid),         32'd0);
        bus.handshake_data  = 7'h11;
        bus.handshake_valid = 1'b1;
        tick(); tick(); tick();
        check("mr_idle_data", 32'(bus.data),          32'h11);
        check("mr_idle_ack",  32'(bus.handshake_ack), 32'd1);
        bus.ready = 1'b1;
        bus.handshake_valid = 1'b0;
        tick(); tick(); tick(); tick();

        // One-cycle valid pulse: synchronized, so exactly one capture
        bus.handshake_data  = 7'h66;
        bus.handshake_valid = 1'b1;
        tick();
        bus.handshake_valid = 1'b0;
        tick();
        check("gl_vld_n1", 32'(bus.valid), 32'd0);
        tick();
        check("gl_vld_n2",  32'(bus.valid),         32'd1);
        check("gl_data",    32'(bus.data),          32'h66);
        check("gl_ack_n2",  32'(bus.handshake_ack), 32'd1);
        tick();
        check("gl_ack_n3",  32'(bus.handshake_ack), 32'd0);
        check("gl_vld_n3",  32'(bus.valid),         32'd0);
        tick(); tick(); tick();
        check("gl_no_dup",  32'(bus.valid),         32'd0);
        check("gl_ack_idle", 32'(bus.handshake_ack), 32'd0);

        // Stream from an asynchronous source with random consumer stalls
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < c_N_STREAM; i++) src_send(c_SIZE'(i));
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    tick();
                    bus.ready = 1'($urandom_range(0, 1));
                end
            end
        join
        tick();
        bus.ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mon_en = 1'b0;
        check("stream_count", 32'(exp_next), 32'(c_N_STREAM));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
